// File: rtl/data_mem_sync.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_sync
// Brief    : Single-clock data memory with byte-enable writes, registered
//            reads (latency 1, write-first), range errors and a hardware
//            zero-fill sequence that runs out of reset and on request.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_err,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                wr_err,
  input  logic                clr_req,
  output logic                busy
);

  localparam int                  c_be_w  = DATA_W / 8;
  localparam int                  c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_idx_w-1:0]  c_last  = c_idx_w'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]     c_depth = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_idx_w-1:0]   r_clr_ptr;
  logic [c_idx_w-1:0]   w_clr_ptr_nxt;

  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 w_idle;
  logic                 w_rd_in_range;
  logic                 w_wr_in_range;
  logic                 w_rd_acc;
  logic                 w_wr_acc;
  logic                 w_bypass;
  logic [c_idx_w-1:0]   w_rd_idx;
  logic [c_idx_w-1:0]   w_wr_idx;
  logic [DATA_W-1:0]    w_rd_old;
  logic [DATA_W-1:0]    w_wr_old;
  logic [DATA_W-1:0]    w_rd_word;
  logic [DATA_W-1:0]    w_wr_word;

  assign w_idle        = (r_state == ST_IDLE);
  assign busy          = ~w_idle;
  // Full-width compare: out-of-range addresses never alias onto real words.
  assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
  assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
  assign w_rd_acc      = w_idle & rd_en;
  assign w_wr_acc      = w_idle & wr_en & w_wr_in_range;
  assign w_bypass      = w_wr_acc & w_rd_in_range & (rd_addr == wr_addr);
  assign w_rd_idx      = rd_addr[c_idx_w-1:0];
  assign w_wr_idx      = wr_addr[c_idx_w-1:0];
  assign w_rd_old      = r_mem[w_rd_idx];
  assign w_wr_old      = r_mem[w_wr_idx];

  // Per-lane merge: the stored word for a write, and the write-first bypass
  // word returned when a read hits the address being written this cycle.
  generate
    for (genvar k = 0; k < c_be_w; k++) begin : g_lane
      assign w_wr_word[8*k +: 8] = wr_be[k] ? wr_data[8*k +: 8] : w_wr_old[8*k +: 8];
      assign w_rd_word[8*k +: 8] = (w_bypass && wr_be[k]) ? wr_data[8*k +: 8]
                                                          : w_rd_old[8*k +: 8];
    end
  endgenerate

  // Array write port: zero-fill while clearing, merged user write when idle.
  always_ff @(posedge clk) begin
    if (!w_idle) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[w_wr_idx] <= w_wr_word;
    end
  end

  // State and clear-pointer registers; reset restarts the clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next-state logic: sweep every word once, then accept clear requests.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_ptr == c_last) begin
          w_state_nxt   = ST_IDLE;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  // Registered response flags and read data; rd_data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= w_rd_acc;
      rd_err   <= w_rd_acc & ~w_rd_in_range;
      wr_err   <= w_idle & wr_en & ~w_wr_in_range;
      if (w_rd_acc) begin
        rd_data <= w_rd_in_range ? w_rd_word : '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32, address port width in bits.
REQ-003 Parameter DEPTH, default 65536, number of words implemented; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rd_en  input  1  read request.
REQ-007 rd_addr  input  ADDR_W  read word address.
REQ-008 rd_data  output  DATA_W  registered read data.
REQ-009 rd_valid  output  1  rd_data is valid this cycle.
REQ-010 rd_err  output  1  accepted read was out of range.
REQ-011 wr_en  input  1  write request.
REQ-012 wr_addr  input  ADDR_W  write word address.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 wr_be  input  DATA_W/8  byte enables; bit k enables bits 8k+7:8k.
REQ-015 wr_err  output  1  accepted write was out of range (registered).
REQ-016 clr_req  input  1  request a full zero-fill of the array.
REQ-017 busy  output  1  clear sequence in progress; requests ignored.

Function
REQ-018 States: CLEAR and IDLE; no other states.
REQ-019 CLEAR: an internal counter clr_ptr starts at 0 and writes all-zero to word clr_ptr each cycle, incrementing by 1; after writing word DEPTH-1 the FSM enters IDLE on the next edge. Duration is exactly DEPTH cycles.
REQ-020 busy SHALL be 1 throughout CLEAR and 0 throughout IDLE.
REQ-021 In IDLE, clr_req=1 enters CLEAR on the next edge with clr_ptr=0; clr_req is ignored while in CLEAR.
REQ-022 In CLEAR, rd_en and wr_en SHALL be ignored: no array write, rd_valid=0, rd_err=0, wr_err=0.
REQ-023 Write (IDLE, wr_en=1, wr_addr<DEPTH): on the edge, each byte lane with wr_be[k]=1 takes wr_data's lane; lanes with wr_be[k]=0 are unchanged.
REQ-024 Write with wr_addr>=DEPTH: array unchanged; wr_err=1 for the following cycle, else wr_err=0.
REQ-025 Read (IDLE, rd_en=1): latency 1; on the next cycle rd_valid=1 and rd_data = word at rd_addr if rd_addr<DEPTH, else rd_data=0 and rd_err=1.
REQ-026 rd_valid and rd_err SHALL be 0 in any cycle not following an accepted read; rd_data holds its last value when rd_valid=0.
REQ-027 Same-cycle read and write to the same in-range address: write-first; rd_data returns the merged post-write word (enabled lanes new, others old).
REQ-028 Address comparison uses the full ADDR_W bits; no truncation or wrap of out-of-range addresses.
REQ-029 wr_be all-zero with wr_en=1 is a legal no-op write; wr_err is still evaluated per REQ-024.
REQ-030 clr_req and a write in the same IDLE cycle: the write completes, then CLEAR starts and overwrites it.

Reset
REQ-031 rst_n=0 immediately forces rd_data=0, rd_valid=0, rd_err=0, wr_err=0, busy=1, state=CLEAR, clr_ptr=0.
REQ-032 Release of rst_n starts the clear sequence; array contents are valid (all zero) only once busy falls.
REQ-033 Reset asserted mid-CLEAR or mid-access aborts it and restarts per REQ-031; no partial write of the current cycle is guaranteed.

Verification (DATA_W=32, ADDR_W=8, DEPTH=16)
REQ-034 Release reset -> busy=1 for exactly 16 cycles, then 0; read each of addresses 0..15 -> rd_data=0, rd_valid=1 one cycle after each request.
REQ-035 Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then wr_data=0x000000AA with wr_be=4'b0001 -> read addr 3 returns 0xDEADBEAA.
REQ-036 Same-cycle write 0x12345678 (wr_be=4'b1100) and read to addr 5 holding 0xFFFFFFFF -> rd_data=0x1234FFFF next cycle.
REQ-037 Write to addr 16 and read addr 200 -> wr_err=1 and rd_err=1 with rd_data=0 next cycle; a subsequent read of addr 0 returns its old value, error flags back to 0.
REQ-038 Fill addrs 0..15 with nonzero data, pulse clr_req with rd_en=1 during clear -> busy=1 for 16 cycles, rd_valid stays 0, then all words read 0.
REQ-039 Assert rst_n=0 at clear cycle 7 for 1 cycle -> outputs zero immediately, busy=1, clear restarts and lasts 16 full cycles after release.
